game_sequencer: RTL and testbench
=================================

Name: game_sequencer

Overview:
- Top-level Pong game-flow controller: sequences idle, serve, play and win phases, keeps both scores, and drives the 2-bit game_state bus consumed by the pixel renderer.
- Also tells the ball/paddle logic when to re-centre the ball, which way to serve, and when motion is frozen.
- Sits between button/ball-collision logic and the renderer; game_state encoding: 00 idle/blank, 01 playing (paddles+ball drawn), 10 player 1 wins, 11 player 2 wins.

Parameters:
WIN_SCORE, 9, points needed to win; legal range 1..15
SERVE_FRAMES, 60, frames ball is held centred before each serve; legal range 1..255
WIN_FRAMES, 180, frames win screen is held before auto-return to idle; legal range 1..255

Ports:
clk  in  1  system/pixel clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse once per video frame
start_btn  in  1  start button level, already synchronised to clk
miss_left  in  1  one-cycle pulse: ball passed paddle 1 (player 2 scores)
miss_right  in  1  one-cycle pulse: ball passed paddle 2 (player 1 scores)
game_state  out  2  00 idle, 01 play/serve, 10 P1 win, 11 P2 win
score1  out  4  player 1 score
score2  out  4  player 2 score
freeze  out  1  1 = ball and paddle motion halted
ball_reset  out  1  one-cycle pulse: re-centre ball
serve_dir  out  1  0 = serve toward player 1 (left), 1 = toward player 2 (right)

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high. While reset=1 at a clk edge:
  - state=IDLE, game_state=00, score1=score2=0, freeze=1, ball_reset=0, serve_dir=0, frame counter=0, start edge register=0.
  - Reset mid-game aborts immediately, with no residual pulse.
- Registers and latency: all outputs are registered. A transition caused by an input sampled at edge N is visible after edge N.
- Start press: start_rise = start_btn & ~start_btn_q, where start_btn_q is registered every cycle.
- IDLE:
  - game_state=00, freeze=1.
  - On start_rise: score1=score2=0, serve_dir=0, pulse ball_reset, counter=0, then go to SERVE.
- SERVE:
  - game_state=01, freeze=1.
  - Counter increments on each frame_tick.
  - When the counter reaches SERVE_FRAMES on a frame_tick, go to PLAY. Counter clears on entry to PLAY.
  - miss_left and miss_right are ignored.
- PLAY: game_state=01, freeze=0. One cycle's inputs are handled as follows:
  - miss_right only: score1+1, serve_dir=1 (loser receives).
  - miss_left only: score2+1, serve_dir=0.
  - miss_left and miss_right in the same cycle: both ignored, no score change.
  - After a score: if the new score equals WIN_SCORE, go to P1_WIN (score1) or P2_WIN (score2), with no ball_reset. Otherwise pulse ball_reset, counter=0, go to SERVE.
  - Scores never exceed WIN_SCORE and never wrap.
- P1_WIN / P2_WIN:
  - game_state=10 / 11 respectively, freeze=1, scores held.
  - Counter increments on frame_tick.
  - Leaves for IDLE when the counter reaches WIN_FRAMES, or earlier on start_rise.
  - Scores stay visible until the next start from IDLE.
- Misses in any state other than PLAY are ignored.
- If start_rise and frame_tick coincide, start_rise has priority.
- ball_reset is high for exactly one cycle per event.

Optional Feature:
- Macro: GAME_PAUSE_EN.
- When defined:
  - Adds input port pause_btn (1 bit, synchronised level) and internal state PAUSED.
  - A rising edge of pause_btn in PLAY or SERVE goes to PAUSED: game_state=01, freeze=1, counter held, misses ignored.
  - The next rising edge returns to the saved state (PLAY or SERVE); the counter resumes from its held value.
  - start_rise in PAUSED is ignored.
  - Reset clears PAUSED.
- When undefined: no pause_btn port, no PAUSED state, behaviour exactly as above.

Test Plan:
- Reset held 3 cycles mid-PLAY with score1=4 -> game_state=00, score1=score2=0, freeze=1, ball_reset=0 on the first cycle after the reset edge.
- In IDLE, start_btn high for 10 cycles -> exactly one ball_reset pulse; game_state=01, freeze=1; PLAY entered on the 60th frame_tick; freeze falls to 0 the following cycle.
- In PLAY, miss_right pulse -> score1 0->1, serve_dir=1, one ball_reset pulse, state SERVE; then miss_left during SERVE -> score2 stays 0.
- score2=8, miss_left in PLAY -> score2=9, game_state=11, no ball_reset; after 180 frame_ticks game_state=00 and score2 still 9; next start_rise clears both scores.
- miss_left and miss_right asserted in the same PLAY cycle -> scores unchanged, state stays PLAY, no ball_reset.
- (GAME_PAUSE_EN) In SERVE with counter=30, pause edge then 50 frame_ticks then pause edge -> state SERVE, PLAY entered after 30 more frame_ticks.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: Pong game-flow controller.
//
// Sequences the idle, serve, play and win phases, keeps both players' scores
// and drives the 2-bit game_state bus read by the pixel renderer. It also
// tells the ball/paddle logic when to re-centre the ball, which way to serve
// and when motion is frozen. Every output is registered.
//
// Parameters:
//   WIN_SCORE    points needed to win (1..15)
//   SERVE_FRAMES frames the ball is held centred before each serve (1..255)
//   WIN_FRAMES   frames the win screen is held before returning to idle (1..255)
//
// Ports:
//   clk         system/pixel clock
//   reset       synchronous, active-high reset
//   frame_tick  one-cycle pulse per video frame
//   start_btn   start button level, synchronised to clk
//   pause_btn   pause button level, synchronised (GAME_PAUSE_EN builds only)
//   miss_left   one-cycle pulse: ball passed paddle 1 (player 2 scores)
//   miss_right  one-cycle pulse: ball passed paddle 2 (player 1 scores)
//   game_state  00 idle, 01 play/serve, 10 P1 wins, 11 P2 wins
//   score1      player 1 score
//   score2      player 2 score
//   freeze      1 = ball and paddle motion halted
//   ball_reset  one-cycle pulse: re-centre ball
//   serve_dir   0 = serve toward player 1 (left), 1 = toward player 2 (right)
//
// Build option:
//   GAME_PAUSE_EN  adds pause_btn and a PAUSED state; a rising edge of
//                  pause_btn toggles pause during SERVE or PLAY.

module game_sequencer #(
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int WIN_FRAMES   = 180
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       start_btn,
`ifdef GAME_PAUSE_EN
   input  logic       pause_btn,
`endif
   input  logic       miss_left,
   input  logic       miss_right,
   output logic [1:0] game_state,
   output logic [3:0] score1,
   output logic [3:0] score2,
   output logic       freeze,
   output logic       ball_reset,
   output logic       serve_dir
);

   typedef enum logic [2:0] {
      IDLE,
      SERVE,
      PLAY,
      P1_WIN,
      P2_WIN
`ifdef GAME_PAUSE_EN
      , PAUSED
`endif
   } state_t;

   state_t     state;
   logic [7:0] counter;
   logic       start_btn_q;
   logic       start_rise;
   logic [8:0] counter_inc;
   logic       serve_done;
   logic       win_done;
   logic [3:0] score1_inc;
   logic [3:0] score2_inc;

`ifdef GAME_PAUSE_EN
   state_t     resume_state;
   logic       pause_btn_q;
   logic       pause_rise;

   assign pause_rise = pause_btn & ~pause_btn_q;
`endif

   // Edge detect on the start button and the "this tick finishes the wait"
   // compares; the counter is widened by one bit so the +1 never wraps.
   assign start_rise  = start_btn & ~start_btn_q;
   assign counter_inc = {1'b0, counter} + 9'd1;
   assign serve_done  = (counter_inc == 9'(SERVE_FRAMES));
   assign win_done    = (counter_inc == 9'(WIN_FRAMES));
   assign score1_inc  = score1 + 4'd1;
   assign score2_inc  = score2 + 4'd1;

   // Game-flow FSM. Outputs are updated alongside each state change so they
   // stay registered; ball_reset defaults low so it only ever pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         game_state  <= 2'b00;
         score1      <= 4'd0;
         score2      <= 4'd0;
         freeze      <= 1'b1;
         ball_reset  <= 1'b0;
         serve_dir   <= 1'b0;
         counter     <= 8'd0;
         start_btn_q <= 1'b0;
`ifdef GAME_PAUSE_EN
         pause_btn_q  <= 1'b0;
         resume_state <= IDLE;
`endif
      end else begin
         start_btn_q <= start_btn;
         ball_reset  <= 1'b0;
`ifdef GAME_PAUSE_EN
         pause_btn_q <= pause_btn;
`endif
         case (state)
            IDLE: begin
               game_state <= 2'b00;
               freeze     <= 1'b1;
               if (start_rise) begin
                  score1     <= 4'd0;
                  score2     <= 4'd0;
                  serve_dir  <= 1'b0;
                  ball_reset <= 1'b1;
                  counter    <= 8'd0;
                  state      <= SERVE;
                  game_state <= 2'b01;
               end
            end

            SERVE: begin
`ifdef GAME_PAUSE_EN
               if (pause_rise) begin
                  resume_state <= SERVE;
                  state        <= PAUSED;
               end else
`endif
               if (frame_tick) begin
                  if (serve_done) begin
                     state   <= PLAY;
                     freeze  <= 1'b0;
                     counter <= 8'd0;
                  end else begin
                     counter <= counter_inc[7:0];
                  end
               end
            end

            PLAY: begin
`ifdef GAME_PAUSE_EN
               if (pause_rise) begin
                  resume_state <= PLAY;
                  state        <= PAUSED;
                  freeze       <= 1'b1;
               end else
`endif
               // Simultaneous misses cancel out; the loser receives the serve.
               if (miss_right && !miss_left) begin
                  score1    <= score1_inc;
                  serve_dir <= 1'b1;
                  freeze    <= 1'b1;
                  counter   <= 8'd0;
                  if (score1_inc == 4'(WIN_SCORE)) begin
                     state      <= P1_WIN;
                     game_state <= 2'b10;
                  end else begin
                     state      <= SERVE;
                     ball_reset <= 1'b1;
                  end
               end else if (miss_left && !miss_right) begin
                  score2    <= score2_inc;
                  serve_dir <= 1'b0;
                  freeze    <= 1'b1;
                  counter   <= 8'd0;
                  if (score2_inc == 4'(WIN_SCORE)) begin
                     state      <= P2_WIN;
                     game_state <= 2'b11;
                  end else begin
                     state      <= SERVE;
                     ball_reset <= 1'b1;
                  end
               end
            end

            P1_WIN, P2_WIN: begin
               // Start press cuts the win screen short and beats a same-cycle tick.
               if (start_rise) begin
                  state      <= IDLE;
                  game_state <= 2'b00;
                  counter    <= 8'd0;
               end else if (frame_tick) begin
                  if (win_done) begin
                     state      <= IDLE;
                     game_state <= 2'b00;
                     counter    <= 8'd0;
                  end else begin
                     counter <= counter_inc[7:0];
                  end
               end
            end

`ifdef GAME_PAUSE_EN
            PAUSED: begin
               // Counter is left untouched so the serve wait resumes where it stopped.
               if (pause_rise) begin
                  state  <= resume_state;
                  freeze <= (resume_state != PLAY);
               end
            end
`endif

            default: begin
               state      <= IDLE;
               game_state <= 2'b00;
               freeze     <= 1'b1;
               counter    <= 8'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer using
// default parameters (WIN_SCORE=9, SERVE_FRAMES=60, WIN_FRAMES=180).
// Inputs change 1 ns after a rising edge and outputs are sampled there too.

module tb_game_sequencer;

   logic       clk;
   logic       reset;
   logic       frame_tick;
   logic       start_btn;
   logic       miss_left;
   logic       miss_right;
`ifdef GAME_PAUSE_EN
   logic       pause_btn;
`endif
   logic [1:0] game_state;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       freeze;
   logic       ball_reset;
   logic       serve_dir;

   int total;
   int bad;
   int pulses;

   game_sequencer dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .start_btn  (start_btn),
`ifdef GAME_PAUSE_EN
      .pause_btn  (pause_btn),
`endif
      .miss_left  (miss_left),
      .miss_right (miss_right),
      .game_state (game_state),
      .score1     (score1),
      .score2     (score2),
      .freeze     (freeze),
      .ball_reset (ball_reset),
      .serve_dir  (serve_dir)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then land 1 ns past the edge that sampled them.
   task automatic applyStimulus(input logic sb, input logic ft, input logic ml, input logic mr);
      start_btn  = sb;
      frame_tick = ft;
      miss_left  = ml;
      miss_right = mr;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // n frame ticks, each followed by a quiet cycle
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      end
   endtask

   // From the start of a serve wait, the 60th tick releases the freeze.
   task automatic serveToPlay(input string tag);
      ticks(59);
      checkOutput({tag, "_frozen59"}, {7'd0, freeze}, 8'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput({tag, "_play"}, {7'd0, freeze}, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      reset      = 1'b1;
      start_btn  = 1'b0;
      frame_tick = 1'b0;
      miss_left  = 1'b0;
      miss_right = 1'b0;
`ifdef GAME_PAUSE_EN
      pause_btn  = 1'b0;
`endif
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

      // Reset state
      checkOutput("rst_state", {6'd0, game_state}, 8'h00);
      checkOutput("rst_score1", {4'd0, score1}, 8'd0);
      checkOutput("rst_score2", {4'd0, score2}, 8'd0);
      checkOutput("rst_freeze", {7'd0, freeze}, 8'd1);
      checkOutput("rst_ballrst", {7'd0, ball_reset}, 8'd0);
      checkOutput("rst_servedir", {7'd0, serve_dir}, 8'd0);

      // Start held 10 cycles: single ball_reset pulse, serving and frozen
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("start_ballrst", {7'd0, ball_reset}, 8'd1);
      checkOutput("start_state", {6'd0, game_state}, 8'h01);
      checkOutput("start_freeze", {7'd0, freeze}, 8'd1);
      pulses = 1;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
         pulses += int'(ball_reset);
      end
      checkOutput("start_pulses", 8'(pulses), 8'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      serveToPlay("serve1");

      // Player 1 scores; misses during the serve wait are ignored
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("p1pt_score1", {4'd0, score1}, 8'd1);
      checkOutput("p1pt_servedir", {7'd0, serve_dir}, 8'd1);
      checkOutput("p1pt_ballrst", {7'd0, ball_reset}, 8'd1);
      checkOutput("p1pt_freeze", {7'd0, freeze}, 8'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("serve_miss_score2", {4'd0, score2}, 8'd0);
      checkOutput("serve_ballrst_low", {7'd0, ball_reset}, 8'd0);
      serveToPlay("serve2");

      // Both misses in one cycle cancel
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("both_score1", {4'd0, score1}, 8'd1);
      checkOutput("both_score2", {4'd0, score2}, 8'd0);
      checkOutput("both_freeze", {7'd0, freeze}, 8'd0);
      checkOutput("both_ballrst", {7'd0, ball_reset}, 8'd0);

      // Bring player 1 to 4 points, then reset mid-play for 3 cycles
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         serveToPlay("serve_p1");
      end
      checkOutput("pre_rst_score1", {4'd0, score1}, 8'd4);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("midrst_state", {6'd0, game_state}, 8'h00);
      checkOutput("midrst_score1", {4'd0, score1}, 8'd0);
      checkOutput("midrst_freeze", {7'd0, freeze}, 8'd1);
      checkOutput("midrst_ballrst", {7'd0, ball_reset}, 8'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("postrst_state", {6'd0, game_state}, 8'h00);

      // Player 2 runs to 9: win screen, no ball_reset
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      serveToPlay("serve_g2");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         serveToPlay("serve_p2");
      end
      checkOutput("p2_score8", {4'd0, score2}, 8'd8);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("p2win_state", {6'd0, game_state}, 8'h03);
      checkOutput("p2win_score2", {4'd0, score2}, 8'd9);
      checkOutput("p2win_ballrst", {7'd0, ball_reset}, 8'd0);
      checkOutput("p2win_freeze", {7'd0, freeze}, 8'd1);
      checkOutput("p2win_servedir", {7'd0, serve_dir}, 8'd0);
      ticks(179);
      checkOutput("p2win_hold179", {6'd0, game_state}, 8'h03);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("p2win_exit", {6'd0, game_state}, 8'h00);
      checkOutput("p2win_exit_score2", {4'd0, score2}, 8'd9);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("idle_miss_score2", {4'd0, score2}, 8'd9);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("restart_score2", {4'd0, score2}, 8'd0);
      checkOutput("restart_state", {6'd0, game_state}, 8'h01);
      checkOutput("restart_ballrst", {7'd0, ball_reset}, 8'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      serveToPlay("serve_g3");

      // Player 1 wins; start press beats a same-cycle frame tick
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         serveToPlay("serve_p1w");
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("p1win_state", {6'd0, game_state}, 8'h02);
      checkOutput("p1win_score1", {4'd0, score1}, 8'd9);
      checkOutput("p1win_ballrst", {7'd0, ball_reset}, 8'd0);
      ticks(5);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("p1win_start_exit", {6'd0, game_state}, 8'h00);
      checkOutput("p1win_exit_score1", {4'd0, score1}, 8'd9);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef GAME_PAUSE_EN
      // Pause at serve count 30, 50 ticks while paused, then 30 more to play
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      ticks(30);
      pause_btn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      pause_btn = 1'b0;
      ticks(50);
      checkOutput("paused_state", {6'd0, game_state}, 8'h01);
      checkOutput("paused_freeze", {7'd0, freeze}, 8'd1);
      pause_btn = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      pause_btn = 1'b0;
      ticks(29);
      checkOutput("resume_frozen29", {7'd0, freeze}, 8'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("resume_play", {7'd0, freeze}, 8'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
